input_conditioner: RTL and testbench
====================================

INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, is the number of consecutive stable clk cycles required to accept a button level change (10 ms at 50 MHz).
REQ-002 Parameter SYNC_STAGES, default 2, is the flip-flop depth of every input synchronizer (legal range 2..3).
REQ-003 The clock port SHALL be clk, input, width 1: the single clock; all logic is rising-edge.
REQ-004 The reset port SHALL be rst, input, width 1: the reset, asynchronous and active-low.
REQ-005 Port swIn SHALL be an input of width 8: raw asynchronous slide switches.
REQ-006 Port btnIn SHALL be an input of width 3: raw asynchronous push buttons, active-high, bouncing.
REQ-007 Port bytePos SHALL be an output of width 8: synchronized switch value presented to the RAM write stage.
REQ-008 Port btn SHALL be an output of width 3: one-cycle press pulses, at most one bit high per cycle.
REQ-009 Port btnLevel SHALL be an output of width 3: debounced button levels.

Function
REQ-010 swIn and btnIn SHALL each pass through a SYNC_STAGES-deep synchronizer before any other use.
REQ-011 Each button SHALL have its own debounce FSM with states IDLE, WAIT_PRESS, PRESSED and WAIT_RELEASE.
REQ-012 IDLE -> WAIT_PRESS when the synced input is 1; the counter clears to 0.
REQ-013 In WAIT_PRESS, each cycle with input 1 SHALL increment the counter; input 0 returns the FSM to IDLE.
REQ-014 WAIT_PRESS -> PRESSED when the counter reaches DEBOUNCE_CYCLES-1 with input 1, and a press event SHALL be raised.
REQ-015 The release path SHALL mirror the press path: PRESSED -> WAIT_RELEASE on input 0, a 1 returns the FSM to PRESSED, and after DEBOUNCE_CYCLES stable zeros the FSM moves to IDLE with no event.
REQ-016 btnLevel[i] SHALL be 1 exactly while FSM i is in PRESSED or WAIT_RELEASE.
REQ-017 Press events SHALL be latched into a 3-bit pending register.
REQ-018 Each cycle, the lowest-index pending bit SHALL be emitted on btn for one cycle and then cleared.
REQ-019 Simultaneous events SHALL therefore emerge on successive cycles, in order 0, 1, 2.
REQ-020 A new event on a bit that is already pending SHALL be merged, with no duplicate pulse.
REQ-021 Latency: btn[i] SHALL rise SYNC_STAGES + DEBOUNCE_CYCLES + 1 cycles after btnIn[i] rises and stays stable, plus one cycle per lower-index pulse queued ahead.
REQ-022 bytePos SHALL follow the synchronized swIn every cycle except while any pending bit is set or btn is nonzero, during which it holds.
REQ-023 bytePos SHALL therefore be stable in the cycle btn pulses and in the cycle before it.
REQ-024 Counters SHALL be sized $clog2(DEBOUNCE_CYCLES) bits, saturate at DEBOUNCE_CYCLES-1 and never wrap.
REQ-025 Glitches shorter than DEBOUNCE_CYCLES SHALL produce no pulse and no btnLevel change.

Reset
REQ-026 rst low SHALL asynchronously force the following: all FSMs to IDLE, counters to 0, the pending register to 0, synchronizers to 0, bytePos to 8'h00, btn to 3'b000 and btnLevel to 3'b000.
REQ-027 Reset asserted mid-debounce or mid-pulse SHALL discard that event, with no pulse after release.
REQ-028 A button held through reset release SHALL be debounced afresh and yield exactly one pulse.

Structure
REQ-029 The FSM state enum and the default DEBOUNCE_CYCLES constant SHALL live in the shared package input_pkg.
REQ-030 One sub-module, debounce_fsm (synchronizer, counter and FSM for one button, emitting level and event), SHALL be instantiated three times.
REQ-031 The pending/priority arbiter and the bytePos hold logic SHALL reside in input_conditioner.

Verification (bench uses DEBOUNCE_CYCLES=4, SYNC_STAGES=2)
REQ-032 Clean press: btnIn=3'b001 held 20 cycles -> btn=3'b001 for exactly one cycle, 7 cycles after the rise; btnLevel[0]=1 until 6 cycles after release.
REQ-033 Bounce: btnIn[1] toggled 1,0,1,0 every cycle, then held 1 -> exactly one btn=3'b010 pulse, 7 cycles after the final rise.
REQ-034 Simultaneous: btnIn 3'b000 -> 3'b111 in one cycle -> btn sequence 3'b001, 3'b010, 3'b100 on three consecutive cycles.
REQ-035 Hold: swIn changes 8'h3C -> 8'hA5 in the cycle the press event latches -> bytePos=8'h3C during the pulse and 8'hA5 two cycles later.
REQ-036 Reset mid-debounce: rst low for 2 cycles after 2 stable cycles of btnIn[2] -> all outputs 0 and no pulse; with btnIn still held, exactly one pulse 7 cycles after rst rises.

Source files
------------

// File: rtl/input_pkg.sv
// Shared types and defaults for the input conditioner: per-button debounce
// state encoding and the default debounce window.
package input_pkg;

    localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        WAIT_PRESS   = 2'd1,
        PRESSED      = 2'd2,
        WAIT_RELEASE = 2'd3
    } btn_state_t;

    // The debounced level is carried by the FSM state itself.
    function automatic logic is_held(btn_state_t s);
        return (s == PRESSED) || (s == WAIT_RELEASE);
    endfunction

endpackage

// File: rtl/debounce_fsm.sv
// One button: input synchronizer, saturating stability counter and the
// press/release debounce FSM. Emits its state and a one-cycle press event.
module debounce_fsm
    import input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int SYNC_STAGES     = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       din,
    output btn_state_t state,
    output logic       evt
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    // The count that, incremented once more with a stable input, reaches CNT_LAST.
    localparam logic [CNT_W-1:0] CNT_ARM  = CNT_W'(DEBOUNCE_CYCLES - 2);

    logic [SYNC_STAGES-1:0] sync;
    logic                   synced;
    logic [CNT_W-1:0]       cnt;

    assign synced = sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], din};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            evt   <= 1'b0;
        end else begin
            evt <= 1'b0;
            case (state)
                IDLE: begin
                    if (synced) begin
                        state <= WAIT_PRESS;
                        cnt   <= '0;
                    end
                end
                WAIT_PRESS: begin
                    if (!synced) begin
                        state <= IDLE;
                    end else if (cnt == CNT_ARM) begin
                        state <= PRESSED;
                        cnt   <= CNT_LAST;
                        evt   <= 1'b1;
                    end else if (cnt != CNT_LAST) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                PRESSED: begin
                    if (!synced) begin
                        state <= WAIT_RELEASE;
                        cnt   <= '0;
                    end
                end
                WAIT_RELEASE: begin
                    if (synced) begin
                        state <= PRESSED;
                    end else if (cnt == CNT_ARM) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt != CNT_LAST) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/input_conditioner.sv
// Board input front end: synchronizes the switches, debounces three buttons
// and serializes their press events onto btn, freezing bytePos around pulses.
module input_conditioner
    import input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int SYNC_STAGES     = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] swIn,
    input  logic [2:0] btnIn,
    output logic [7:0] bytePos,
    output logic [2:0] btn,
    output logic [2:0] btnLevel
);

    logic [SYNC_STAGES-1:0][7:0] sw_sync;
    btn_state_t                  fsm_state [3];
    logic [2:0]                  evt;
    logic [2:0]                  pending;
    logic [2:0]                  merged;
    logic [2:0]                  grant;

    for (genvar i = 0; i < 3; i++) begin : g_btn
        debounce_fsm #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .SYNC_STAGES    (SYNC_STAGES)
        ) u_debounce (
            .clk  (clk),
            .rst  (rst),
            .din  (btnIn[i]),
            .state(fsm_state[i]),
            .evt  (evt[i])
        );
        assign btnLevel[i] = is_held(fsm_state[i]);
    end

    // Fresh events merge into pending; the lowest set bit wins this cycle.
    assign merged = pending | evt;
    assign grant  = merged & (~merged + 3'd1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sw_sync <= '0;
            pending <= '0;
            btn     <= '0;
            bytePos <= '0;
        end else begin
            sw_sync <= {sw_sync[SYNC_STAGES-2:0], swIn};
            pending <= merged & ~grant;
            btn     <= grant;
            // Hold from the event cycle through the pulse so the write stage sees a stable byte.
            if (!((|merged) || (|btn))) begin
                bytePos <= sw_sync[SYNC_STAGES-1];
            end
        end
    end

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with a 4-cycle debounce window and
// 2-stage synchronizers; expected values are hand-derived cycle counts.
module tb_input_conditioner;

    logic       clk;
    logic       rst;
    logic [7:0] swIn;
    logic [2:0] btnIn;
    logic [7:0] bytePos;
    logic [2:0] btn;
    logic [2:0] btnLevel;

    int compared   = 0;
    int mismatched = 0;

    input_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .SYNC_STAGES    (2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .swIn    (swIn),
        .btnIn   (btnIn),
        .bytePos (bytePos),
        .btn     (btn),
        .btnLevel(btnLevel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle; inputs change and outputs are read here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [2:0] exp_btn;
        logic [2:0] seen_btn;
        logic [2:0] seen_lvl;

        rst   = 1'b0;
        swIn  = 8'h3C;
        btnIn = 3'b000;

        // Reset state
        ticks(2);
        check("reset_bytepos", bytePos, 8'h00);
        check("reset_btn", {5'd0, btn}, 8'h00);
        check("reset_btnlevel", {5'd0, btnLevel}, 8'h00);
        rst = 1'b1;
        ticks(5);
        check("bytepos_follows", bytePos, 8'h3C);

        // Clean press on button 0, with swIn changing as the event latches
        btnIn = 3'b001;
        for (int k = 1; k <= 20; k++) begin
            tick();
            exp_btn = (k == 7) ? 3'b001 : 3'b000;
            if (k <= 10) check($sformatf("press0_btn_k%0d", k), {5'd0, btn}, {5'd0, exp_btn});
            if (k == 5) check("press0_level_before", {7'd0, btnLevel[0]}, 8'h00);
            if (k == 6) begin
                check("press0_level_rise", {7'd0, btnLevel[0]}, 8'h01);
                swIn = 8'hA5;
            end
            if (k == 7) check("hold_during_pulse", bytePos, 8'h3C);
            if (k == 8) check("hold_after_pulse", bytePos, 8'h3C);
            if (k == 9) check("bytepos_updates", bytePos, 8'hA5);
        end
        btnIn = 3'b000;
        seen_btn = 3'b000;
        for (int j = 1; j <= 8; j++) begin
            tick();
            seen_btn |= btn;
            if (j == 5) check("release0_level_held", {7'd0, btnLevel[0]}, 8'h01);
            if (j == 6) check("release0_level_drop", {7'd0, btnLevel[0]}, 8'h00);
        end
        check("release0_no_pulse", {5'd0, seen_btn}, 8'h00);

        // Glitch one cycle shorter than the window
        btnIn = 3'b001;
        ticks(3);
        btnIn = 3'b000;
        seen_btn = 3'b000;
        seen_lvl = 3'b000;
        for (int j = 0; j < 10; j++) begin
            tick();
            seen_btn |= btn;
            seen_lvl |= btnLevel;
        end
        check("glitch_no_pulse", {5'd0, seen_btn}, 8'h00);
        check("glitch_no_level", {5'd0, seen_lvl}, 8'h00);

        // Bounce on button 1: 1,0,1,0 then held
        btnIn = 3'b010; tick();
        btnIn = 3'b000; tick();
        btnIn = 3'b010; tick();
        btnIn = 3'b000; tick();
        btnIn = 3'b010;
        for (int k = 1; k <= 12; k++) begin
            tick();
            exp_btn = (k == 7) ? 3'b010 : 3'b000;
            check($sformatf("bounce1_btn_k%0d", k), {5'd0, btn}, {5'd0, exp_btn});
        end
        btnIn = 3'b000;
        ticks(10);
        check("bounce1_released", {5'd0, btnLevel}, 8'h00);

        // Simultaneous presses serialize in index order
        btnIn = 3'b111;
        for (int k = 1; k <= 12; k++) begin
            tick();
            case (k)
                7:       exp_btn = 3'b001;
                8:       exp_btn = 3'b010;
                9:       exp_btn = 3'b100;
                default: exp_btn = 3'b000;
            endcase
            check($sformatf("simul_btn_k%0d", k), {5'd0, btn}, {5'd0, exp_btn});
        end
        check("simul_levels", {5'd0, btnLevel}, 8'h07);
        btnIn = 3'b000;
        ticks(10);

        // Reset mid-debounce on button 2, button held through reset release
        btnIn = 3'b100;
        ticks(4);
        rst = 1'b0;
        tick();
        check("midrst_btn", {5'd0, btn}, 8'h00);
        check("midrst_level", {5'd0, btnLevel}, 8'h00);
        check("midrst_bytepos", bytePos, 8'h00);
        tick();
        check("midrst_btn_2", {5'd0, btn}, 8'h00);
        rst = 1'b1;
        seen_btn = 3'b000;
        for (int k = 1; k <= 14; k++) begin
            tick();
            exp_btn = (k == 7) ? 3'b100 : 3'b000;
            check($sformatf("postrst_btn_k%0d", k), {5'd0, btn}, {5'd0, exp_btn});
        end
        check("postrst_level", {5'd0, btnLevel}, 8'h04);
        check("postrst_bytepos", bytePos, 8'hA5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
